// File: rtl/fifo_pkg.sv
// Shared sizing helpers and FSM state type for the FIFO write arbiter.
package fifo_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Index width for an n-entry selector, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after the start
// pointer, wrapping modulo N (N need not be a power of two).
module rr_pick import fifo_pkg::*; #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]              i_req,
  input  logic [idx_width(N)-1:0]   i_start,
  output logic [idx_width(N)-1:0]   o_idx,
  output logic                      o_found
);

  localparam int unsigned IW = idx_width(N);

  int w_pos;

  // Scan farthest-to-nearest so the closest hit to the start pointer wins.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_pos   = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      w_pos = (int'(i_start) + k) % int'(N);
      if (i_req[w_pos]) begin
        o_idx   = IW'(w_pos);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter funnelling N requesters into one shared FIFO write
// port; one arbitration cycle per grant, bursts of up to BURST_LEN words.
module fifo_wr_arbiter import fifo_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  input  logic                          fifo_full,
  output logic                          write_enable,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic                          grant_valid,
  output logic [idx_width(N_REQ)-1:0]   grant_idx
);

  localparam int unsigned IW = idx_width(N_REQ);
  localparam int unsigned CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_REQ - 1);

  state_t                r_state;
  logic [IW-1:0]         r_grant_idx;
  logic [IW-1:0]         r_rr_ptr;
  logic [CW-1:0]         r_beat_cnt;

  logic [IW-1:0]         w_pick_idx;
  logic                  w_pick_found;
  logic                  w_sel_valid;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_accept;
  logic [IW-1:0]         w_next_ptr;

  rr_pick #(.N(N_REQ)) u_rr_pick (
    .i_req   (req_valid),
    .i_start (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  // Granted requester's valid/word and the one-hot ready toward it.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    req_ready   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (r_grant_idx == IW'(i)) begin
        w_sel_valid  = req_valid[i];
        w_sel_data   = req_data[i*int'(DATA_WIDTH) +: DATA_WIDTH];
        req_ready[i] = (r_state == ST_BURST) && !fifo_full;
      end
    end
  end

  assign grant_valid  = (r_state == ST_BURST);
  assign grant_idx    = r_grant_idx;
  assign w_accept     = grant_valid && w_sel_valid && !fifo_full;
  assign write_enable = w_accept;
  assign write_data   = w_accept ? w_sel_data : '0;
  assign w_next_ptr   = (r_grant_idx == LAST_IDX) ? '0 : r_grant_idx + IW'(1);

  // Full with valid holds the grant and beat count; a dropped valid ends it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
      r_beat_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_found) begin
            r_grant_idx <= w_pick_idx;
            r_beat_cnt  <= '0;
            r_state     <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (!w_sel_valid) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= w_next_ptr;
          end else if (w_accept) begin
            if (r_beat_cnt == LAST_BEAT) begin
              r_state  <= ST_IDLE;
              r_rr_ptr <= w_next_ptr;
            end else begin
              r_beat_cnt <= r_beat_cnt + CW'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 8, width of requester and FIFO write data.
REQ-002 Parameter: N_REQ, 4, number of requesters (2..8).
REQ-003 Parameter: BURST_LEN, 4, max consecutive words per grant (1..16).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  N_REQ  requester i has a word on req_data[i].
REQ-007 req_data  input  N_REQ x DATA_WIDTH  packed requester words, slice i = requester i.
REQ-008 req_ready  output  N_REQ  word of requester i accepted this cycle when valid&ready.
REQ-009 fifo_full  input  1  full flag from the shared fifo_memory.
REQ-010 write_enable  output  1  drives fifo_memory write_enable.
REQ-011 write_data  output  DATA_WIDTH  drives fifo_memory write_data.
REQ-012 grant_valid  output  1  high in BURST state.
REQ-013 grant_idx  output  clog2(N_REQ)  currently granted requester.

Function
REQ-014 FSM states SHALL be IDLE and BURST only.
REQ-015 IDLE: if any req_valid, pick first set bit searching rr_ptr, rr_ptr+1, ... wrapping modulo N_REQ; register it in grant_idx, clear beat_cnt, go to BURST next edge.
REQ-016 IDLE with no req_valid: stay in IDLE, rr_ptr unchanged.
REQ-017 Arbitration overhead SHALL be exactly one cycle (IDLE cycle) per grant; no word accepted in IDLE.
REQ-018 req_ready[i] SHALL be combinational: 1 only when state=BURST, i=grant_idx, fifo_full=0; all other bits 0.
REQ-019 write_enable = req_valid[grant_idx] & req_ready[grant_idx]; write_data = req_data[grant_idx] (zero-latency pass-through); write_data = 0 when write_enable=0.
REQ-020 Accepted beat with beat_cnt < BURST_LEN-1: beat_cnt increments, stay in BURST.
REQ-021 Accepted beat with beat_cnt = BURST_LEN-1: go to IDLE, rr_ptr = (grant_idx+1) mod N_REQ.
REQ-022 BURST with req_valid[grant_idx]=0: no write, go to IDLE, rr_ptr = (grant_idx+1) mod N_REQ.
REQ-023 BURST with fifo_full=1 and valid=1: no write, stay in BURST, beat_cnt held (stall, grant not lost).
REQ-024 fifo_full rising mid-burst SHALL block write that same cycle (no write into a full FIFO ever).
REQ-025 Non-granted requesters' valid changes SHALL not affect the current burst.
REQ-026 beat_cnt width clog2(BURST_LEN)+1; rr_ptr and grant_idx wrap modulo N_REQ (non-power-of-two N_REQ supported).

Reset
REQ-027 rst=1 SHALL immediately force: state IDLE, rr_ptr 0, grant_idx 0, beat_cnt 0, grant_valid 0, req_ready 0, write_enable 0, write_data 0.
REQ-028 Reset mid-burst SHALL abandon the burst with no write in the reset cycle; first grant after reset starts search at requester 0.

Structure
REQ-029 Shared package fifo_pkg SHALL hold DATA_WIDTH default, the FSM state enum (ST_IDLE, ST_BURST), and the clog2-based index width helper.
REQ-030 One sub-module rr_pick (combinational round-robin priority picker: req vector + start pointer -> index + found) SHALL be used; FSM and counters remain in fifo_wr_arbiter.
REQ-031 Bench SHALL instantiate fifo_wr_arbiter driving fifo_memory (ADDR_WIDTH=10) and a per-requester scoreboard model.

Verification
REQ-032 Single requester 2 streaming 10 words, others idle -> bursts of 4,4,2 with one IDLE gap between bursts; FIFO reads return words in order.
REQ-033 All four valid continuously, 4 words each -> grants 0,1,2,3 in order, 16 writes in 20 cycles, per-requester order preserved.
REQ-034 Requester 1 drops valid after 2 of 4 beats while 3 waiting -> burst ends, next grant is 3, rr_ptr=2 then 0 after grant 3.
REQ-035 FIFO prefilled with 1023 words, requester 0 sends 3 -> 1 accepted, full asserts, req_ready=0 and grant held; read 2 words -> remaining 2 accepted, beat_cnt resumes at 1.
REQ-036 rst asserted mid-burst (beat 2 of requester 2) -> outputs zero same cycle, no write; after release with requesters 1 and 3 valid -> first grant is 1.
REQ-037 N_REQ=3, BURST_LEN=1, all valid -> grant sequence 0,1,2,0,1,2, exactly one word per grant.
